// File: rtl/stop_watch_ctrl_pkg.sv
// rtl/stop_watch_ctrl_pkg.sv - shared state codes, display patterns and width helper for the stopwatch controller
package stop_watch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_LAP   = 3'd4
  } sw_state_t;

  localparam logic [3:0] DP_LIVE = 4'b0101;
  localparam logic [3:0] DP_LAP  = 4'b1010;
  localparam logic [3:0] DP_SET  = 4'b1111;
  localparam logic       DIR_UP  = 1'b1;

  // Counters run 0..n-1, so clog2(n) bits suffice; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stop_watch_ctrl_btn_debounce.sv
// rtl/stop_watch_ctrl_btn_debounce.sv - 2-FF synchroniser plus stability counter; one-cycle pulse on accepted press
module btn_debounce
  import stop_watch_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int unsigned CW = cnt_width(DB_CYCLES);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // The counter only advances while the synced input disagrees with the accepted level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync        <= 2'b00;
      level       <= 1'b0;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync        <= {sync[0], btn_raw};
      press_pulse <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level       <= sync[1];
        cnt         <= '0;
        press_pulse <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stop_watch_ctrl.sv
// rtl/stop_watch_ctrl.sv - stopwatch mode FSM, button debounce and display select
// Optional lap capture/hold is built when STOP_WATCH_LAP_EN is defined.
module stop_watch_ctrl
  import stop_watch_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES       = 1_000_000,
  parameter int unsigned LAP_HOLD_CYCLES = 300_000_000,
  parameter int unsigned BLINK_CYCLES    = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_mode,
  input  logic       btn_dir,
  input  logic [3:0] live_d3,
  input  logic [3:0] live_d2,
  input  logic [3:0] live_d1,
  input  logic [3:0] live_d0,
  input  logic       live_zero,
  output logic       sw_pause,
  output logic       sw_set,
  output logic       sw_clr,
  output logic       sw_up,
  output logic [3:0] disp_d3,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d0,
  output logic [3:0] disp_dp,
  output logic [2:0] state_o
);

  localparam int unsigned BW = cnt_width(BLINK_CYCLES);

  sw_state_t     state;
  logic          start_p, lap_p, mode_p;
  logic          go_start, go_lap, go_mode;
  logic          underflow;
  logic [1:0]    dir_sync;
  logic [BW-1:0] blink_cnt;

`ifdef STOP_WATCH_LAP_EN
  localparam int unsigned HW = cnt_width(LAP_HOLD_CYCLES);
  logic [HW-1:0] hold_cnt;
  logic [3:0]    lap_d3, lap_d2, lap_d1, lap_d0;
`endif

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk(clk), .reset(reset), .btn_raw(btn_start), .press_pulse(start_p));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk(clk), .reset(reset), .btn_raw(btn_lap), .press_pulse(lap_p));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk(clk), .reset(reset), .btn_raw(btn_mode), .press_pulse(mode_p));

  // Only the highest-priority pulse of a cycle is allowed to act.
  assign go_start  = start_p;
  assign go_lap    = lap_p & ~start_p;
  assign go_mode   = mode_p & ~start_p & ~lap_p;
  assign underflow = (sw_up != DIR_UP) && live_zero;
  assign state_o   = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dir_sync <= {DIR_UP, DIR_UP};
    else        dir_sync <= {dir_sync[0], btn_dir};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      sw_pause  <= 1'b1;
      sw_set    <= 1'b0;
      sw_clr    <= 1'b0;
      sw_up     <= DIR_UP;
      disp_d3   <= 4'd0;
      disp_d2   <= 4'd0;
      disp_d1   <= 4'd0;
      disp_d0   <= 4'd0;
      disp_dp   <= DP_LIVE;
      blink_cnt <= '0;
`ifdef STOP_WATCH_LAP_EN
      hold_cnt  <= '0;
      lap_d3    <= 4'd0;
      lap_d2    <= 4'd0;
      lap_d1    <= 4'd0;
      lap_d0    <= 4'd0;
`endif
    end else begin
      sw_clr  <= 1'b0;
      disp_d3 <= live_d3;
      disp_d2 <= live_d2;
      disp_d1 <= live_d1;
      disp_d0 <= live_d0;
      disp_dp <= DP_LIVE;
      if (state == ST_IDLE || state == ST_SET) sw_up <= dir_sync[1];

      case (state)
        ST_IDLE: begin
          if (go_start) begin
            state    <= ST_RUN;
            sw_pause <= 1'b0;
          end else if (go_lap) begin
            sw_clr <= 1'b1;
          end else if (go_mode) begin
            state     <= ST_SET;
            sw_set    <= 1'b1;
            disp_dp   <= DP_SET;
            blink_cnt <= '0;
          end
        end
        ST_SET: begin
          if (go_mode) begin
            state  <= ST_IDLE;
            sw_set <= 1'b0;
          end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            disp_dp   <= ~disp_dp;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
            disp_dp   <= disp_dp;
          end
        end
        ST_RUN: begin
          if (underflow) begin
            state    <= ST_IDLE;
            sw_pause <= 1'b1;
          end else if (go_start) begin
            state    <= ST_PAUSE;
            sw_pause <= 1'b1;
          end
`ifdef STOP_WATCH_LAP_EN
          else if (go_lap) begin
            state    <= ST_LAP;
            lap_d3   <= live_d3;
            lap_d2   <= live_d2;
            lap_d1   <= live_d1;
            lap_d0   <= live_d0;
            hold_cnt <= HW'(LAP_HOLD_CYCLES - 1);
            disp_dp  <= DP_LAP;
          end
`endif
        end
        ST_PAUSE: begin
          if (go_start) begin
            state    <= ST_RUN;
            sw_pause <= 1'b0;
          end else if (go_lap) begin
            state  <= ST_IDLE;
            sw_clr <= 1'b1;
          end
        end
`ifdef STOP_WATCH_LAP_EN
        ST_LAP: begin
          if (underflow) begin
            state    <= ST_IDLE;
            sw_pause <= 1'b1;
          end else if (go_start) begin
            state    <= ST_PAUSE;
            sw_pause <= 1'b1;
          end else if (go_lap) begin
            lap_d3   <= live_d3;
            lap_d2   <= live_d2;
            lap_d1   <= live_d1;
            lap_d0   <= live_d0;
            hold_cnt <= HW'(LAP_HOLD_CYCLES - 1);
            disp_dp  <= DP_LAP;
          end else if (hold_cnt == '0) begin
            state <= ST_RUN;
          end else begin
            // Entry and re-latch already show live (== latched) digits; hold them from here on.
            hold_cnt <= hold_cnt - HW'(1);
            disp_d3  <= lap_d3;
            disp_d2  <= lap_d2;
            disp_d1  <= lap_d1;
            disp_d0  <= lap_d0;
            disp_dp  <= DP_LAP;
          end
        end
`endif
        default: begin
          state    <= ST_IDLE;
          sw_pause <= 1'b1;
          sw_set   <= 1'b0;
        end
      endcase
    end
  end

endmodule
